// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline buffer types and MEM-stage FSM encoding
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
  } ctrl_word_t;

  typedef struct packed {
    logic [31:0] pc_rdata;
    logic [31:0] insn;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_data_t;

  typedef struct packed {
    ctrl_word_t  ctrl_wd;
    logic [31:0] alu_out;
    logic [31:0] mar;
    logic [31:0] mem_data_out;
    logic [31:0] u_imm;
    logic [4:0]  rd;
    rvfi_data_t  rvfi_d;
  } EX_MEM_stage_t;

  typedef struct packed {
    ctrl_word_t  ctrl_wd;
    logic [31:0] alu_out;
    logic [31:0] rdata;
    logic [31:0] u_imm;
    logic [4:0]  rd;
    rvfi_data_t  rvfi_d;
  } MEM_WB_stage_t;

endpackage

// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - selects the addressed byte/half of a load word and extends it per funct3
module load_align_ext
  import rv32i_types::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_word >> {i_offset, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  always_comb begin
    o_rdata = i_word;
    case (i_funct3)
      LB:      o_rdata = {{24{w_byte[7]}}, w_byte};
      LBU:     o_rdata = {24'h0, w_byte};
      LH:      o_rdata = {{16{w_half[15]}}, w_half};
      LHU:     o_rdata = {16'h0, w_half};
      default: o_rdata = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I MEM stage: data-cache access FSM, load extend, stall counter
// Optional RVFI memory-field population: define MEM_ACCESS_RVFI_EN.
module mem_access_stage
  import rv32i_types::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  EX_MEM_stage_t          mem_in,
  input  logic                   pipe_hold,
  input  logic                   dmem_resp,
  input  logic [31:0]            dmem_rdata,
  output logic [31:0]            dmem_address,
  output logic                   dmem_read,
  output logic                   dmem_write,
  output logic [3:0]             dmem_mbe,
  output logic [31:0]            dmem_wdata,
  output logic                   mem_stall,
  output logic                   misaligned,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output MEM_WB_stage_t          mem_out
);

  mem_state_t             r_state;
  mem_state_t             w_next_state;
  logic [31:0]            r_rdata;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic        w_is_read;
  logic        w_is_write;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_memop;
  logic        w_capture;
  logic [31:0] w_src_word;
  logic [31:0] w_load_data;

  assign w_is_read  = mem_in.ctrl_wd.mem_read;
  assign w_is_write = mem_in.ctrl_wd.mem_write;
  assign w_is_half  = (mem_in.ctrl_wd.funct3[1:0] == 2'b01);
  assign w_is_word  = (mem_in.ctrl_wd.funct3[1:0] == 2'b10);
  assign misaligned = (w_is_read | w_is_write) &
                      ((w_is_half & mem_in.mar[0]) | (w_is_word & (mem_in.mar[1:0] != 2'b00)));
  assign w_memop    = (w_is_read | w_is_write) & ~misaligned;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // A response with no live request (e.g. late after a reset) leaves the FSM idle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, WAIT: begin
        if (w_memop && dmem_resp) w_next_state = pipe_hold ? DONE : IDLE;
        else if (w_memop)         w_next_state = WAIT;
        else                      w_next_state = IDLE;
      end
      DONE:    if (!pipe_hold) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    mem_stall  = 1'b0;
    w_capture  = 1'b0;
    w_src_word = dmem_rdata;
    if (r_state == DONE) begin
      w_src_word = r_rdata;
    end else begin
      dmem_read  = w_memop & w_is_read;
      dmem_write = w_memop & w_is_write;
      mem_stall  = w_memop & ~dmem_resp;
      w_capture  = w_memop & dmem_resp & pipe_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            r_rdata <= 32'h0;
    else if (w_capture) r_rdata <= dmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst)                            r_stall_cnt <= '0;
    else if (mem_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  assign stall_cycles = r_stall_cnt;
  assign dmem_address = {mem_in.mar[31:2], 2'b00};
  assign dmem_wdata   = mem_in.mem_data_out;

  always_comb begin
    dmem_mbe = 4'b0000;
    if (w_memop && w_is_write) begin
      case (mem_in.ctrl_wd.funct3)
        SB:      dmem_mbe = 4'b0001 << mem_in.mar[1:0];
        SH:      dmem_mbe = 4'b0011 << mem_in.mar[1:0];
        default: dmem_mbe = 4'b1111;
      endcase
    end else if (w_memop) begin
      dmem_mbe = 4'b1111;
    end
  end

  load_align_ext u_load_align_ext (
    .i_word   (w_src_word),
    .i_offset (mem_in.mar[1:0]),
    .i_funct3 (mem_in.ctrl_wd.funct3),
    .o_rdata  (w_load_data)
  );

  always_comb begin
    mem_out         = '0;
    mem_out.ctrl_wd = mem_in.ctrl_wd;
    mem_out.alu_out = mem_in.alu_out;
    mem_out.rdata   = w_load_data;
    mem_out.u_imm   = mem_in.u_imm;
    mem_out.rd      = mem_in.rd;
    mem_out.rvfi_d  = mem_in.rvfi_d;
    if (misaligned) mem_out.ctrl_wd.load_regfile = 1'b0;
`ifdef MEM_ACCESS_RVFI_EN
    mem_out.rvfi_d.mem_addr  = dmem_address;
    mem_out.rvfi_d.mem_rmask = (w_memop & w_is_read)  ? dmem_mbe : 4'b0000;
    mem_out.rvfi_d.mem_wmask = (w_memop & w_is_write) ? dmem_mbe : 4'b0000;
    mem_out.rvfi_d.mem_rdata = w_src_word;
    mem_out.rvfi_d.mem_wdata = dmem_wdata;
`endif
  end

endmodule
